// File: rtl/handshake_tx_pkg.sv
// Shared types for the handshake_tx block: FSM state encoding, FIFO entry layout
// and the per-entry check-bit helper.
package handshake_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       out;
    } entry_t;

    // Check bit stored with every entry; evaluated on the low nibble at push time.
    function automatic logic check_bit(input logic [3:0] nib);
        return (|nib) & (&nib);
    endfunction

endpackage

// File: rtl/handshake_tx_fifo.sv
// Storage for handshake_tx: DEPTH-entry circular buffer with occupancy count.
// Push is refused when full and pop when empty, so callers may offer either freely.
module handshake_tx_fifo
    import handshake_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   wr_entry,
    output entry_t                   rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == {CW{1'b0}});
    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;
    assign count    = count_r;
    assign rd_entry = mem_r[rd_ptr_r];

    // Storage, pointers (power-of-2 depth wraps naturally) and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{data: 8'h00, out: 1'b0};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_entry;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/handshake_tx.sv
// Load-to-handshake transmitter: buffers {in2,in1} beats and presents them with a
// valid/ready handshake; flush drains the queue. Define HANDSHAKE_TX_ASSERT_EN for assertions.
module handshake_tx
    import handshake_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [3:0]               in1,
    input  logic [3:0]               in2,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic                     flush,
    output logic                     handshake_valid,
    input  logic                     handshake_ready,
    output logic [7:0]               data,
    output logic                     out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e          state_r;
    state_e          next_state_s;
    logic            valid_r;
    logic            load_ready_s;
    logic            busy_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [CW-1:0]   count_s;
    logic [CW-1:0]   count_next_s;
    entry_t          wr_entry_s;
    entry_t          head_s;

    assign push_s     = load_valid && load_ready_s;
    assign pop_s      = valid_r && handshake_ready;
    assign wr_entry_s = '{data: {in2, in1}, out: check_bit(in1)};

    handshake_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (push_s),
        .pop      (pop_s),
        .wr_entry (wr_entry_s),
        .rd_entry (head_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // Occupancy after this cycle's transfers; drives the FSM and the valid flop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_s + CW'(1);
            2'b01:   count_next_s = count_s - CW'(1);
            default: count_next_s = count_s;
        endcase
    end

    // State register and registered valid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            valid_r <= (count_next_s != {CW{1'b0}});
        end
    end

    // Next-state logic; a flush coinciding with a push still takes the push.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (push_s) next_state_s = ACTIVE;
                else        next_state_s = IDLE;
            end
            ACTIVE: begin
                if (flush)                                 next_state_s = DRAIN;
                else if (count_next_s == {CW{1'b0}})       next_state_s = IDLE;
                else                                       next_state_s = ACTIVE;
            end
            DRAIN: begin
                if (count_next_s == {CW{1'b0}}) next_state_s = IDLE;
                else                            next_state_s = DRAIN;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Outputs depend only on flops, never on handshake_ready.
    always_comb begin
        load_ready_s = !full_s && (state_r != DRAIN);
        busy_s       = (state_r != IDLE);
    end

    assign load_ready      = load_ready_s;
    assign busy            = busy_s;
    assign handshake_valid = valid_r;
    assign data            = head_s.data;
    assign out             = head_s.out;
    assign count           = count_s;

`ifdef HANDSHAKE_TX_ASSERT_EN
    a_valid_hold: assert property (@(posedge CLK) disable iff (RESET)
        handshake_valid && !handshake_ready |=> handshake_valid);
    a_stall_stable: assert property (@(posedge CLK) disable iff (RESET)
        handshake_valid && !handshake_ready |=> $stable(data) && $stable(out));
    a_no_push_full: assert property (@(posedge CLK) disable iff (RESET)
        full_s |-> !(load_valid && load_ready));
    a_count_max: assert property (@(posedge CLK) disable iff (RESET)
        count <= CW'(DEPTH));
    a_check_bit: assert property (@(posedge CLK) disable iff (RESET)
        handshake_valid |-> (out == ((|data[3:0]) & (&data[3:0]))));
`else
    // Default build carries no assertion logic.
`endif

endmodule

// File: tb/tb_handshake_tx.sv
// Self-checking bench for handshake_tx: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_handshake_tx;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [3:0]    in1, in2;
    logic          load_valid, flush, handshake_ready;
    logic          load_ready, handshake_valid, out, busy;
    logic [7:0]    data;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;

    logic [8:0] q[$];   // {check, data}; front is the head beat
    bit         drn;    // block is draining after a flush
    bit         chk_en = 1'b0;

    handshake_tx #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .in1(in1), .in2(in2),
        .load_valid(load_valid), .load_ready(load_ready), .flush(flush),
        .handshake_valid(handshake_valid), .handshake_ready(handshake_ready),
        .data(data), .out(out), .count(count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the rules say happens on this clock edge, from the inputs seen there.
    task automatic model_step();
        bit rdy, vld, busy_b, push, pop;
        if (RESET) begin
            q.delete();
            drn = 1'b0;
        end else begin
            rdy    = (q.size() < DEPTH) && !drn;
            vld    = (q.size() != 0);
            busy_b = (q.size() != 0) || drn;
            push   = load_valid && rdy;
            pop    = handshake_ready && vld;
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({(in1 == 4'hF), in2, in1});
            if (drn) drn = (q.size() != 0);
            else     drn = flush && busy_b;
        end
    endtask

    task automatic cyc(input logic lv, input logic [3:0] a, input logic [3:0] b,
                       input logic hr, input logic fl, input logic rs);
        load_valid = lv; in1 = a; in2 = b;
        handshake_ready = hr; flush = fl; RESET = rs;
        @(posedge CLK);
        model_step();
        #2;
    endtask

    // Compare process: DUT against the model on every falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("valid", handshake_valid, q.size() != 0);
            cmp("load_ready", load_ready, (q.size() < DEPTH) && !drn);
            cmp("busy", busy, (q.size() != 0) || drn);
            cmp("count", count, q.size());
            if (q.size() != 0) begin
                cmp("data", data, q[0][7:0]);
                cmp("out", out, q[0][8]);
            end
        end
    end

    initial begin
        logic [7:0] w;
        RESET = 1'b1; in1 = 4'h0; in2 = 4'h0;
        load_valid = 1'b0; flush = 1'b0; handshake_ready = 1'b0;
        @(posedge CLK);
        model_step();
        #2;
        chk_en = 1'b1;

        // Reset state
        cmp("rst_valid", handshake_valid, 1'b0);
        cmp("rst_ready", load_ready, 1'b1);
        cmp("rst_busy", busy, 1'b0);
        cmp("rst_count", count, 3'd0);
        cmp("rst_data", data, 8'h00);
        cmp("rst_out", out, 1'b0);

        // Basic load
        cyc(1'b1, 4'hF, 4'hA, 1'b0, 1'b0, 1'b0);
        cmp("basic_valid", handshake_valid, 1'b1);
        cmp("basic_data", data, 8'hAF);
        cmp("basic_out", out, 1'b1);
        cmp("basic_busy", busy, 1'b1);
        cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        cmp("basic_idle", busy, 1'b0);

        // Backpressure: fill, try one extra, then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 1), 4'hC, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0);
        cmp("bp_count", count, 3'd4);
        cmp("bp_ready", load_ready, 1'b0);
        cmp("bp_held", data, 8'hC1);
        for (int i = 0; i < 4; i++) begin
            w = 8'hC1 + 8'(i);
            cmp("bp_order", data, w);
            cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        end
        cmp("bp_idle", busy, 1'b0);

        // Simultaneous push and pop at count 2
        cyc(1'b1, 4'h1, 4'hD, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 4'hD, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 4'hD, 1'b1, 1'b0, 1'b0);
        cmp("sim_count", count, 3'd2);
        cmp("sim_head", data, 8'hD2);
        cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        cmp("sim_next", data, 8'hD3);
        cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Flush with three queued words; loads offered during drain are refused
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 1), 4'hE, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        cmp("fl_ready", load_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            w = 8'hE1 + 8'(i);
            cmp("fl_order", data, w);
            cyc(1'b1, 4'h7, 4'h7, 1'b1, 1'b0, 1'b0);
        end
        cmp("fl_idle", busy, 1'b0);
        cmp("fl_ready_back", load_ready, 1'b1);
        cmp("fl_count", count, 3'd0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 4), 4'h5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1);
        cmp("mrst_valid", handshake_valid, 1'b0);
        cmp("mrst_count", count, 3'd0);
        cmp("mrst_busy", busy, 1'b0);

        // Check bit
        cyc(1'b1, 4'h1, 4'h5, 1'b0, 1'b0, 1'b0);
        cmp("chk_1", out, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0);
        cmp("chk_0", out, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'hF, 4'h5, 1'b0, 1'b0, 1'b0);
        cmp("chk_F", out, 1'b1);
        cyc(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                4'($urandom),
                ($urandom_range(0, 2) != 0) ^ (n[9]),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 199) == 0));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/handshake_tx.md
HANDSHAKE_TX -- requirements
Module: handshake_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries; must be a power of 2 and at least 2.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in1, input, 4 bits: load payload, low nibble.
REQ-005 SHALL have port in2, input, 4 bits: load payload, high nibble.
REQ-006 SHALL have port load_valid, input, 1 bit: the producer offers {in2,in1}.
REQ-007 SHALL have port load_ready, output, 1 bit: the block can accept a load.
REQ-008 SHALL have port flush, input, 1 bit: a 1-cycle pulse that requests a drain.
REQ-009 SHALL have port handshake_valid, output, 1 bit: a beat is presented to the consumer.
REQ-010 SHALL have port handshake_ready, input, 1 bit: the consumer accepts the beat.
REQ-011 SHALL have port data, output, 8 bits: the head entry {in2,in1}.
REQ-012 SHALL have port out, output, 1 bit: the head entry's check bit.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits: occupancy.
REQ-014 SHALL have port busy, output, 1 bit: the FSM is not IDLE.

Function
REQ-015 SHALL push on load_valid && load_ready, storing data {in2,in1} and out = (|in1) & (&in1) computed at push.
REQ-016 SHALL pop on handshake_valid && handshake_ready.
REQ-017 SHALL drive load_ready = !full && state != DRAIN, with no combinational dependence on handshake_ready.
REQ-018 SHALL register handshake_valid = (count != 0): push in cycle N gives the earliest valid in cycle N+1, with no bypass.
REQ-019 SHALL hold data and out stable while handshake_valid && !handshake_ready.
REQ-020 SHALL never drop handshake_valid before it is accepted.
REQ-021 SHALL update count by +1 on push only, -1 on pop only, and 0 on both.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL, when full, accept no push; a pop in that cycle frees the slot for the next cycle only.
REQ-024 SHALL, when empty, never pop: handshake_ready is ignored while valid is low.
REQ-025 SHALL implement FSM states IDLE, ACTIVE and DRAIN, with busy = (state != IDLE).
REQ-026 SHALL move IDLE->ACTIVE on push.
REQ-027 SHALL move ACTIVE->IDLE when the count reaches 0 after a pop with no push.
REQ-028 SHALL move ACTIVE->DRAIN on flush.
REQ-029 SHALL move DRAIN->IDLE when the count reaches 0.
REQ-030 SHALL ignore flush in IDLE and in DRAIN.
REQ-031 SHALL, when flush and a push coincide in ACTIVE, take the push, then enter DRAIN.
REQ-032 SHALL let DRAIN deliver every queued entry in order and accept no loads.

Reset
REQ-033 SHALL, while RESET is high at a clock edge, clear the pointers and count and set state IDLE.
REQ-034 SHALL, in the cycle after that edge, drive handshake_valid=0, load_ready=1, busy=0, count=0, data=0 and out=0.
REQ-035 SHALL, on RESET mid-transfer, discard all entries; the dropped valid is not a protocol violation.
REQ-036 SHALL have RESET override push, pop and flush in the same cycle.

Configuration
REQ-037 SHALL, with HANDSHAKE_TX_ASSERT_EN defined, compile concurrent assertions on CLK, disabled while RESET: valid held until ready; data/out stable while stalled; no push when full; count <= DEPTH; out == (|data[3:0]) & (&data[3:0]) when valid.
REQ-038 SHALL, without HANDSHAKE_TX_ASSERT_EN, contain no assertions, with identical functional behaviour.

Structure
REQ-039 SHALL place the state enum (IDLE, ACTIVE, DRAIN) and the entry struct {data[7:0], out} in package handshake_tx_pkg.
REQ-040 SHALL instantiate one sub-module, handshake_tx_fifo (storage, pointers, count, full/empty), with the FSM and handshake logic in handshake_tx.

Verification
REQ-041 SHALL verify basic: after reset, load in1=4'hF, in2=4'hA -> the next cycle shows valid=1, data=8'hAF, out=1, busy=1.
REQ-042 SHALL verify backpressure: load 4 words with ready=0 -> count=4, load_ready=0, data held; then ready=1 for 4 cycles -> words come out in order, and the state returns to IDLE.
REQ-043 SHALL verify simultaneous: count=2 with push and pop in the same cycle -> count stays 2, and order is preserved.
REQ-044 SHALL verify flush: 3 queued words and a flush pulse -> load_ready=0, 3 beats delivered, then IDLE with load_ready=1.
REQ-045 SHALL verify reset mid-operation: count=3 and RESET high for 1 cycle -> valid=0, count=0, busy=0 in the next cycle.
REQ-046 SHALL verify check bit: in1=4'h1 -> out=0; in1=4'h0 -> out=0; in1=4'hF -> out=1.
